// File: rtl/sel_mux_pipe_if.sv
// rtl/sel_mux_pipe_if.sv - handshake and data bundle for the registered select stage
interface sel_mux_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH-1:0]       sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic [15:0]          err_cnt;

    modport master (
        output in_valid, sel, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_cnt
    );

    modport slave (
        input  in_valid, sel, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_err, err_cnt
    );
endinterface

// File: rtl/sel_mux_pipe.sv
// rtl/sel_mux_pipe.sv - N-channel registered operand select with skid buffer and error count
module sel_mux_pipe #(
    parameter int               WIDTH   = 32,
    parameter int               NCH     = 4,
    parameter int               SELW    = 2,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] OOR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    sel_mux_pipe_if.slave bus
);
    // State encoding is {skidValid, mainValid} so in_ready is a plain register bit.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] mainData;
    logic             mainErr;
    logic [WIDTH-1:0] skidData;
    logic             skidErr;
    logic [15:0]      errCnt;

    logic [WIDTH-1:0] pickData;
    logic             pickErr;
    int               pickOnes;
    logic             beatIn;
    logic             beatOut;
    logic             loadMainIn;
    logic             loadMainSkid;
    logic             loadSkid;

    assign bus.in_ready  = ~state[1];
    assign bus.out_valid = state[0];
    assign bus.out_data  = mainData;
    assign bus.out_err   = mainErr;
    assign bus.err_cnt   = errCnt;

    assign beatIn  = bus.in_valid & ~state[1];
    assign beatOut = state[0] & bus.out_ready;

    // Channel pick: a beat is legal only when exactly one channel matches.
    // An out-of-range binary index matches nothing, so both modes share the test.
    always_comb begin
        pickData = '0;
        pickOnes = 0;
        for (int k = 0; k < NCH; k++) begin
            if ((MODE == 0) ? (int'(bus.sel[SELW-1:0]) == k) : bus.sel[k]) begin
                pickData = pickData | bus.in_data[k*WIDTH +: WIDTH];
                pickOnes = pickOnes + 1;
            end
        end
        pickErr = (pickOnes != 1);
        if (pickErr) begin
            pickData = OOR_VAL;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Next occupancy and register load strobes; flush overrides everything.
    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (beatIn) begin
                    stateNext  = ONE;
                    loadMainIn = 1'b1;
                end
            end
            ONE: begin
                if (beatIn && beatOut) begin
                    loadMainIn = 1'b1;
                end else if (beatIn) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (beatOut) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (beatOut) begin
                    stateNext    = ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        if (bus.flush) begin
            stateNext    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    // Main and skid data registers; main holds its value while nothing is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= '0;
            mainErr  <= 1'b0;
            skidData <= '0;
            skidErr  <= 1'b0;
        end else begin
            if (loadMainIn) begin
                mainData <= pickData;
                mainErr  <= pickErr;
            end else if (loadMainSkid) begin
                mainData <= skidData;
                mainErr  <= skidErr;
            end
            if (loadSkid) begin
                skidData <= pickData;
                skidErr  <= pickErr;
            end
        end
    end

    // Saturating count of illegal beats that were actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt <= '0;
        end else if (beatIn && pickErr && !bus.flush && (errCnt != 16'hFFFF)) begin
            errCnt <= errCnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb/tb_sel_mux_pipe.sv - directed vector bench for sel_mux_pipe
module tb_sel_mux_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sel_mux_pipe_if #(.WIDTH(32), .NCH(4)) busA ();
    sel_mux_pipe_if #(.WIDTH(32), .NCH(3)) busB ();
    sel_mux_pipe_if #(.WIDTH(32), .NCH(4)) busC ();

    sel_mux_pipe #(.WIDTH(32), .NCH(4), .SELW(2), .MODE(0), .OOR_VAL(32'hDEADBEEF))
        uA (.clk(clk), .rst_n(rst_n), .bus(busA));
    sel_mux_pipe #(.WIDTH(32), .NCH(3), .SELW(2), .MODE(0), .OOR_VAL(32'hDEADBEEF))
        uB (.clk(clk), .rst_n(rst_n), .bus(busB));
    sel_mux_pipe #(.WIDTH(32), .NCH(4), .SELW(2), .MODE(1), .OOR_VAL(32'hDEADBEEF))
        uC (.clk(clk), .rst_n(rst_n), .bus(busC));

    typedef struct {
        int          which;
        logic [3:0]  sel;
        logic [31:0] expData;
        logic        expErr;
        logic [15:0] expCnt;
    } vecT;

    vecT vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic [3:0] s);
        busA.in_valid = (which == 0);
        busB.in_valid = (which == 1);
        busC.in_valid = (which == 2);
        busA.sel = s;
        busB.sel = s[2:0];
        busC.sel = s;
    endtask

    task automatic sample(input int which, output logic v, output logic [31:0] d,
                          output logic e, output logic [15:0] c, output logic r);
        case (which)
            0:       begin v = busA.out_valid; d = busA.out_data; e = busA.out_err; c = busA.err_cnt; r = busA.in_ready; end
            1:       begin v = busB.out_valid; d = busB.out_data; e = busB.out_err; c = busB.err_cnt; r = busB.in_ready; end
            default: begin v = busC.out_valid; d = busC.out_data; e = busC.out_err; c = busC.err_cnt; r = busC.in_ready; end
        endcase
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        v;
        logic [31:0] d;
        logic        e;
        logic [15:0] c;
        logic        r;
        string       nm;

        checks = 0;
        errors = 0;

        vecs[0]  = '{0, 4'd0,    32'h11,       1'b0, 16'd0};
        vecs[1]  = '{0, 4'd1,    32'h22,       1'b0, 16'd0};
        vecs[2]  = '{0, 4'd2,    32'h33,       1'b0, 16'd0};
        vecs[3]  = '{0, 4'd3,    32'h44,       1'b0, 16'd0};
        vecs[4]  = '{1, 4'd0,    32'h11,       1'b0, 16'd0};
        vecs[5]  = '{1, 4'd3,    32'hDEADBEEF, 1'b1, 16'd1};
        vecs[6]  = '{1, 4'd2,    32'h33,       1'b0, 16'd1};
        vecs[7]  = '{2, 4'b0100, 32'h33,       1'b0, 16'd0};
        vecs[8]  = '{2, 4'b0000, 32'hDEADBEEF, 1'b1, 16'd1};
        vecs[9]  = '{2, 4'b0110, 32'hDEADBEEF, 1'b1, 16'd2};
        vecs[10] = '{2, 4'b1000, 32'h44,       1'b0, 16'd2};
        vecs[11] = '{2, 4'b0001, 32'h11,       1'b0, 16'd2};
        vecs[12] = '{0, 4'd3,    32'h44,       1'b0, 16'd0};

        rst_n = 1'b0;
        busA.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        busB.in_data = {32'h33, 32'h22, 32'h11};
        busC.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        busA.flush = 1'b0; busB.flush = 1'b0; busC.flush = 1'b0;
        busA.out_ready = 1'b1; busB.out_ready = 1'b1; busC.out_ready = 1'b1;
        drive(-1, 4'd0);

        // Reset state
        tick;
        check("rst_out_valid", 32'(busA.out_valid), 32'd0);
        check("rst_in_ready", 32'(busA.in_ready), 32'd1);
        check("rst_out_data", busA.out_data, 32'd0);
        check("rst_out_err", 32'(busA.out_err), 32'd0);
        check("rst_err_cnt", 32'(busA.err_cnt), 32'd0);
        #4;
        rst_n = 1'b1;

        // Table: one beat per cycle, out_ready high, checked one edge after accept
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].which, vecs[i].sel);
            tick;
            sample(vecs[i].which, v, d, e, c, r);
            nm = $sformatf("vec%0d", i);
            check({nm, "_valid"}, 32'(v), 32'd1);
            check({nm, "_data"}, d, vecs[i].expData);
            check({nm, "_err"}, 32'(e), 32'(vecs[i].expErr));
            check({nm, "_cnt"}, 32'(c), 32'(vecs[i].expCnt));
            check({nm, "_ready"}, 32'(r), 32'd1);
        end
        drive(-1, 4'd0);
        tick;
        check("drain_valid", 32'(busA.out_valid), 32'd0);

        // Backpressure: A,B,C with out_ready low for three edges once A is out
        drive(0, 4'd0);
        tick;
        check("bp_a_out", busA.out_data, 32'h11);
        busA.out_ready = 1'b0;
        drive(0, 4'd1);
        tick;
        check("bp_hold1_data", busA.out_data, 32'h11);
        check("bp_hold1_valid", 32'(busA.out_valid), 32'd1);
        check("bp_hold1_ready", 32'(busA.in_ready), 32'd0);
        drive(0, 4'd2);
        for (int k = 2; k <= 3; k++) begin
            tick;
            check($sformatf("bp_hold%0d_data", k), busA.out_data, 32'h11);
            check($sformatf("bp_hold%0d_ready", k), 32'(busA.in_ready), 32'd0);
        end
        busA.out_ready = 1'b1;
        tick;
        check("bp_b_data", busA.out_data, 32'h22);
        check("bp_b_valid", 32'(busA.out_valid), 32'd1);
        check("bp_b_ready", 32'(busA.in_ready), 32'd1);
        tick;
        check("bp_c_data", busA.out_data, 32'h33);
        check("bp_c_valid", 32'(busA.out_valid), 32'd1);
        drive(-1, 4'd0);
        tick;
        check("bp_end_valid", 32'(busA.out_valid), 32'd0);

        // Flush in FULL with a beat presented
        busA.out_ready = 1'b0;
        drive(0, 4'd0);
        tick;
        drive(0, 4'd1);
        tick;
        check("fl_full_ready", 32'(busA.in_ready), 32'd0);
        busA.flush = 1'b1;
        drive(0, 4'd2);
        tick;
        busA.flush = 1'b0;
        check("fl_valid", 32'(busA.out_valid), 32'd0);
        check("fl_ready", 32'(busA.in_ready), 32'd1);
        check("fl_cnt", 32'(busA.err_cnt), 32'd0);
        drive(-1, 4'd0);
        tick;
        check("fl_lost_valid", 32'(busA.out_valid), 32'd0);
        busA.out_ready = 1'b1;

        // Flush while an illegal beat would otherwise be accepted
        busB.flush = 1'b1;
        drive(1, 4'd3);
        tick;
        busB.flush = 1'b0;
        drive(-1, 4'd0);
        check("fl2_valid", 32'(busB.out_valid), 32'd0);
        check("fl2_cnt", 32'(busB.err_cnt), 32'd1);
        tick;
        check("fl2_lost_valid", 32'(busB.out_valid), 32'd0);

        // Reset asserted between edges while FULL
        busB.out_ready = 1'b0;
        drive(1, 4'd3);
        tick;
        drive(1, 4'd0);
        tick;
        drive(-1, 4'd0);
        check("rf_full_ready", 32'(busB.in_ready), 32'd0);
        check("rf_cnt_before", 32'(busB.err_cnt), 32'd2);
        check("rf_data_before", busB.out_data, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_valid", 32'(busB.out_valid), 32'd0);
        check("rf_data", busB.out_data, 32'd0);
        check("rf_err", 32'(busB.out_err), 32'd0);
        check("rf_cnt", 32'(busB.err_cnt), 32'd0);
        check("rf_ready", 32'(busB.in_ready), 32'd1);
        check("rf_cnt_c", 32'(busC.err_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        busB.out_ready = 1'b1;
        drive(1, 4'd1);
        tick;
        drive(-1, 4'd0);
        check("rf_post_valid", 32'(busB.out_valid), 32'd1);
        check("rf_post_data", busB.out_data, 32'h22);
        check("rf_post_err", 32'(busB.out_err), 32'd0);
        tick;
        check("rf_post_drain", 32'(busB.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

Parametrised N-channel, WIDTH-bit operand select stage with a registered output and a valid/ready handshake. It replaces the fixed 2:1 and 3:1 combinational selectors on the pipeline's forwarding and writeback paths wherever a registered, stallable select is needed. Binary or one-hot selection is supported. An illegal select produces a defined default value, raises a flag and increments an error counter. A two-entry skid buffer gives full throughput under backpressure.

## Interface
- WIDTH, 32, data width of each channel and of the output
- NCH, 4, number of input channels (2..16)
- SELW, 2, width of `sel` in binary mode; must equal ceil(log2(NCH))
- MODE, 0, 0 = binary select on `sel[SELW-1:0]`, 1 = one-hot select on `sel[NCH-1:0]`
- OOR_VAL, 0, WIDTH-bit value output for an illegal select
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sel  in  NCH  channel select; binary mode uses only bits [SELW-1:0]
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- flush  in  1  synchronous discard of all held beats
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  WIDTH  selected data
- out_err  out  1  current output beat came from an illegal select
- err_cnt  out  16  saturating count of accepted illegal beats

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Release: `out_valid && out_ready` at a rising edge.
- Selection is evaluated on the input side at accept time, and the selected word is captured with its error bit.
  - Binary mode: a select is illegal when `sel[SELW-1:0] >= NCH`.
  - One-hot mode: a select is illegal when `sel` has zero set bits or more than one set bit.
  - An illegal beat stores OOR_VAL with err=1. A legal beat stores the selected channel with err=0.
- Storage is a main register (drives outputs) plus a skid register. The state is set by the two valid bits.
- State EMPTY (main invalid):
  - accept -> ONE.
- State ONE (main valid, skid empty):
  - accept and release -> ONE (new beat into main).
  - accept without release -> FULL (new beat into skid).
  - release without accept -> EMPTY.
  - neither -> ONE (hold).
- State FULL:
  - no accept is possible.
  - release -> ONE (skid moves to main).
  - otherwise hold.
- `in_ready = !skid_valid`, driven from a register with no combinational path from `out_ready`.
- Beat order is preserved. No beat is dropped or duplicated except by flush.
- Flush has priority over accept and release in the same cycle.
  - Both valid bits clear, giving EMPTY next cycle.
  - A beat presented in the flush cycle is discarded.
  - err_cnt is not affected by discarded beats.
- err_cnt increments by 1 on each accepted illegal beat and saturates at 16'hFFFF. It is never cleared except by reset.
- While `out_valid=0`, out_data and out_err hold their last values. Their value is don't-care for downstream.

## Timing
- Latency: a beat accepted at edge N is on out_data with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- After out_ready falls, at most one further beat is accepted (into skid), then in_ready=0.
- in_ready returns to 1 the cycle after the skid drains.
- Reset (rst_n low, asynchronous, effective immediately):
  - out_valid=0, out_data=0, out_err=0, err_cnt=0.
  - both valid bits 0, so in_ready=1.
  - State EMPTY.
- Deassertion of rst_n is synchronous to clk externally. The first accept can occur at the first edge with rst_n high.
- Reset asserted mid-transfer discards all held beats. No partial beat survives.
- in_data and sel are sampled only at the accept edge. They may change freely in other cycles.
- Under backpressure (out_valid=1, out_ready=0), out_data, out_err and out_valid must not change except by flush or reset.

## Test plan
- Binary, NCH=4, WIDTH=32, out_ready=1, in_data ch0..3 = 0x11,0x22,0x33,0x44:
  - Drive sel=0,1,2,3 on consecutive cycles.
  - Required: out_data 0x11,0x22,0x33,0x44 on cycles 1..4, out_err=0 throughout, err_cnt=0.
- Binary, NCH=3, OOR_VAL=0xDEADBEEF:
  - Drive sel=3 for one beat.
  - Required: out_data=0xDEADBEEF with out_err=1 one cycle later, err_cnt=1.
- One-hot, NCH=4:
  - Drive sel=4'b0100, then 4'b0000, then 4'b0110.
  - Required: ch2 data with err=0, then OOR_VAL with err=1 twice, err_cnt=2.
- Backpressure, streaming beats A,B,C with out_ready low for 3 cycles starting when A is on the output:
  - Required: A held stable, B in skid, in_ready=0, C not accepted.
  - On out_ready=1: A,B,C delivered in order with no gaps after the first.
- Flush in FULL state, with in_valid=1 in the same cycle:
  - Required: out_valid=0 and in_ready=1 next cycle, the presented beat is lost, err_cnt unchanged.
- Reset mid-FULL:
  - Assert rst_n=0 between edges.
  - Required: out_valid, out_data, out_err and err_cnt read 0 immediately. After release, the first accepted beat appears one cycle later.
